// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Fetch stage sitting right after the PC register. It issues one instruction
// memory read at a time over a req/ack handshake and buffers {pc, instruction}
// pairs in a small FIFO for the decode stage. The increment output feeds the
// PC register: INC_STEP in the cycle a fetch retires into the FIFO, zero
// otherwise, so the PC only advances when fetch makes progress.
//
// Ports:
//   clk         clock, all state changes on posedge
//   in          synchronous active-low reset (0 at posedge resets)
//   pc          current PC value from the PC register
//   increment   step returned to the PC register (combinational)
//   imem_req    memory read request
//   imem_addr   read address, held stable while imem_req is high
//   imem_ack    read data valid, only meaningful while imem_req is high
//   imem_rdata  instruction word, captured when imem_ack is high
//   flush       discard queued entries and any in-flight fetch
//   dec_valid   head entry available to decode
//   dec_ready   decode accepts the head entry
//   dec_pc      pc of the head entry
//   dec_instr   instruction of the head entry
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int INC_STEP = 4
) (
  input  logic            clk,
  input  logic            in,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] increment,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [XLEN-1:0] INC_C   = XLEN'(INC_STEP);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;

  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_pc_d    [DEPTH];
  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_instr_d [DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push_s;
  logic            pop_s;

  // The address register only changes in IDLE, so it is stable for the whole
  // WAIT period.
  assign imem_addr = addr_q;
  assign dec_valid = (count_q != {CW{1'b0}});
  assign dec_pc    = mem_pc_q[rd_ptr_q];
  assign dec_instr = mem_instr_q[rd_ptr_q];
  assign pop_s     = dec_valid & dec_ready;

  // Fetch FSM: issue, wait for ack, decide whether the returned word is kept.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drop_d    = drop_q;
    imem_req  = 1'b0;
    push_s    = 1'b0;
    increment = {XLEN{1'b0}};
    case (state_q)
      ST_IDLE: begin
        // With only one fetch in flight, room at issue implies room at ack.
        if ((count_q < DEPTH_C) && !flush) begin
          state_d = ST_WAIT;
          addr_d  = pc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !flush) begin
            push_s    = 1'b1;
            increment = INC_C;
          end else begin
            push_s    = 1'b0;
            increment = {XLEN{1'b0}};
          end
        end else if (flush) begin
          // The memory transaction cannot be abandoned; remember to discard it.
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    if (flush) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_pc_d[wr_ptr_q]    = addr_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!in) begin
      state_q     <= ST_IDLE;
      addr_q      <= {XLEN{1'b0}};
      drop_q      <= 1'b0;
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      mem_pc_q    <= '{default: {XLEN{1'b0}}};
      mem_instr_q <= '{default: {XLEN{1'b0}}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. The bench plays both the PC register (it
// adds the increment output to pc after each edge) and the instruction
// memory (acks are driven explicitly per cycle). Expected {pc, instr} pairs
// are queued when an ack that should be accepted is driven and are compared
// when decode pops the head entry.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] increment;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            flush;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;

  int checks;
  int errors;
  int exp_count;
  logic [63:0] sb[$];

  fetch_queue #(.DEPTH(4), .XLEN(XLEN), .INC_STEP(4)) dut (
    .clk        (clk),
    .in         (rst_n),
    .pc         (pc),
    .increment  (increment),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_pc     (dec_pc),
    .dec_instr  (dec_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory model returns for a given address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Close out the current cycle: check decode/increment, update the model,
  // clock the DUT and advance the bench-side PC register.
  task automatic clk_cycle(input logic exp_push, input logic [31:0] exp_addr);
    logic [63:0] e;
    logic [31:0] inc_s;
    chk("dec_valid", {63'd0, dec_valid}, {63'd0, exp_count != 0});
    chk("increment", {32'd0, increment}, exp_push ? 64'd4 : 64'd0);
    if (flush) begin
      exp_count = 0;
      sb.delete();
    end else begin
      if (exp_count != 0 && dec_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("dec_pc", {32'd0, dec_pc}, {32'd0, e[63:32]});
          chk("dec_instr", {32'd0, dec_instr}, {32'd0, e[31:0]});
        end
        exp_count--;
      end
      if (exp_push) begin
        sb.push_back({exp_addr, instr_of(exp_addr)});
        exp_count++;
      end
    end
    inc_s = increment;
    @(posedge clk);
    #1;
    pc = pc + inc_s;
  endtask

  // WAIT portion of a fetch: lat cycles without ack, then an accepted ack.
  task automatic wait_ack(input int lat, input logic [31:0] a);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      #1;
      chk("req_wait", {63'd0, imem_req}, 64'd1);
      chk("addr_wait", {32'd0, imem_addr}, {32'd0, a});
      clk_cycle(1'b0, a);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr_of(a);
    #1;
    chk("req_ack", {63'd0, imem_req}, 64'd1);
    chk("addr_ack", {32'd0, imem_addr}, {32'd0, a});
    clk_cycle(1'b1, a);
    imem_ack = 1'b0;
  endtask

  // Full fetch: one IDLE issue cycle followed by the WAIT portion.
  task automatic fetch(input int lat, input logic [31:0] a);
    imem_ack = 1'b0;
    #1;
    chk("req_idle", {63'd0, imem_req}, 64'd0);
    clk_cycle(1'b0, a);
    wait_ack(lat, a);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_inc", {32'd0, increment}, 64'd0);
    rst_n     = 1'b1;
    pc        = 32'h0;
    exp_count = 0;
    sb.delete();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_count  = 0;
    rst_n      = 1'b0;
    pc         = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    flush      = 1'b0;
    dec_ready  = 1'b1;

    // 1: one-cycle memory latency, decode always ready
    do_reset();
    dec_ready = 1'b1;
    fetch(1, 32'h0);
    fetch(1, 32'h4);
    fetch(1, 32'h8);
    #1;
    chk("t1_req_idle", {63'd0, imem_req}, 64'd0);
    clk_cycle(1'b0, 32'h0);

    // 2: decode stalled, zero-latency memory fills the queue
    do_reset();
    dec_ready = 1'b0;
    fetch(0, 32'h0);
    fetch(0, 32'h4);
    fetch(0, 32'h8);
    fetch(0, 32'hC);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_full_req", {63'd0, imem_req}, 64'd0);
      chk("t2_head_pc", {32'd0, dec_pc}, 64'h0);
      clk_cycle(1'b0, 32'h0);
    end
    dec_ready = 1'b1;
    #1;
    chk("t2_drain_req", {63'd0, imem_req}, 64'd0);
    clk_cycle(1'b0, 32'h0);
    chk("t2_pc_resume", {32'd0, pc}, 64'h10);
    fetch(0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      #1;
      clk_cycle(1'b0, 32'h0);
    end

    // 3: three-cycle memory latency
    do_reset();
    dec_ready = 1'b1;
    fetch(3, 32'h0);
    #1;
    clk_cycle(1'b0, 32'h0);

    // 4: flush during WAIT with two entries queued, ack two cycles later
    do_reset();
    dec_ready = 1'b0;
    fetch(0, 32'h0);
    fetch(0, 32'h4);
    #1;
    chk("t4_issue", {63'd0, imem_req}, 64'd0);
    clk_cycle(1'b0, 32'h0);
    flush = 1'b1;
    #1;
    chk("t4_req_flush", {63'd0, imem_req}, 64'd1);
    chk("t4_addr_flush", {32'd0, imem_addr}, 64'h8);
    clk_cycle(1'b0, 32'h0);
    flush = 1'b0;
    #1;
    chk("t4_req_hold", {63'd0, imem_req}, 64'd1);
    chk("t4_addr_hold", {32'd0, imem_addr}, 64'h8);
    clk_cycle(1'b0, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0008;
    #1;
    chk("t4_req_ack", {63'd0, imem_req}, 64'd1);
    clk_cycle(1'b0, 32'h0);
    imem_ack  = 1'b0;
    pc        = 32'h40;
    dec_ready = 1'b1;
    fetch(1, 32'h40);
    #1;
    clk_cycle(1'b0, 32'h0);

    // 5: flush coincides with ack while decode is ready
    do_reset();
    dec_ready = 1'b0;
    fetch(0, 32'h0);
    #1;
    clk_cycle(1'b0, 32'h0);
    dec_ready  = 1'b1;
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0004;
    #1;
    chk("t5_req", {63'd0, imem_req}, 64'd1);
    clk_cycle(1'b0, 32'h0);
    flush    = 1'b0;
    imem_ack = 1'b0;
    chk("t5_pc_hold", {32'd0, pc}, 64'h4);
    fetch(1, 32'h4);
    #1;
    clk_cycle(1'b0, 32'h0);

    // 6: reset in the middle of WAIT with three entries queued
    do_reset();
    dec_ready = 1'b0;
    fetch(0, 32'h0);
    fetch(0, 32'h4);
    fetch(0, 32'h8);
    #1;
    clk_cycle(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_req_pre", {63'd0, imem_req}, 64'd1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_000C;
    exp_count  = 0;
    sb.delete();
    pc = 32'h200;
    #1;
    chk("t6_req", {63'd0, imem_req}, 64'd0);
    chk("t6_valid", {63'd0, dec_valid}, 64'd0);
    chk("t6_inc", {32'd0, increment}, 64'd0);
    clk_cycle(1'b0, 32'h0);
    imem_ack  = 1'b0;
    dec_ready = 1'b1;
    wait_ack(1, 32'h200);
    #1;
    clk_cycle(1'b0, 32'h0);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage directly downstream of the PC register. It takes the current pc, performs one instruction-memory read at a time over a req/ack handshake, and buffers {pc, instruction} pairs in a FIFO toward decode.
- Its increment output drives the PC's increment input: INC_STEP on a completed fetch, 0 otherwise. The PC therefore stalls whenever fetch stalls.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- XLEN, 32, width of pc, address and instruction
- INC_STEP, 4, byte step returned to the PC per completed fetch

Ports:
- clk  input  1  clock, all state updates on posedge
- in  input  1  reset, synchronous, active-low (in==0 at posedge resets)
- pc  input  XLEN  current PC value from the PC register
- increment  output  XLEN  step for the PC register (combinational)
- imem_req  output  1  memory read request
- imem_addr  output  XLEN  read address, stable while imem_req=1
- imem_ack  input  1  read data valid; only meaningful while imem_req=1
- imem_rdata  input  XLEN  instruction word, sampled when imem_ack=1
- flush  input  1  discard queue and any in-flight fetch
- dec_valid  output  1  head entry available
- dec_ready  input  1  decode accepts head
- dec_pc  output  XLEN  pc of head entry
- dec_instr  output  XLEN  instruction of head entry

Behaviour:
- FSM states: IDLE, WAIT. Registers: state, addr_q, drop_q, FIFO storage, rd_ptr, wr_ptr, count (0..DEPTH).
- Reset (in==0 at posedge): state=IDLE, count=0, pointers=0, drop_q=0, addr_q=0. Resulting outputs: imem_req=0, dec_valid=0, increment=0. dec_pc/dec_instr are don't-care while dec_valid=0.
- IDLE → WAIT when count<DEPTH and flush=0; addr_q<=pc. Otherwise remain in IDLE.
- WAIT: imem_req=1 and imem_addr=addr_q, held constant until ack. Ack may arrive any number of cycles later, including the first WAIT cycle.
- WAIT with imem_ack=1 → IDLE in the same cycle.
  - If drop_q=0 and flush=0: push {addr_q, imem_rdata} and drive increment=INC_STEP that cycle.
  - Otherwise discard the data, drive increment=0, and clear drop_q.
- increment=0 in every other cycle. The PC therefore advances at the same edge the fetch retires, and the next IDLE cycle sees the new pc. Minimum 2 cycles per fetch.
- flush while in WAIT without ack sets drop_q=1; the request stays asserted until ack, because the memory transaction is never abandoned.
- flush in any state: count<=0 and pointers reset at the next posedge; dec_valid=0 in the following cycle. A flush has priority over any push or pop in the same cycle.
- dec_valid = (count!=0). dec_pc and dec_instr are read combinationally from the entry at rd_ptr.
- Pop occurs when dec_valid & dec_ready. A pop when empty cannot happen.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Room check: because there is only one fetch in flight, count<DEPTH at issue guarantees space at ack, since count can only fall meanwhile. A push never happens when full.
- Pointers wrap modulo DEPTH.
- Reset during WAIT: the FSM returns to IDLE immediately. imem_req drops, and any late ack is ignored because imem_req=0.
- No arithmetic is done on pc inside this block. increment is zero-extended INC_STEP.

Test Plan:
- Reset then pc=0x0, imem_ack 1 cycle after each req, dec_ready=1 → requests to 0x0,0x4,0x8; increment=4 in each ack cycle; decode sees (0x0,I0),(0x4,I1),(0x8,I2) in order.
- dec_ready=0, zero-latency memory, DEPTH=4 → exactly 4 entries pushed, count=4, imem_req stays 0, increment stays 0; raising dec_ready drains 0x0..0xC and fetching resumes at 0x10.
- Variable latency (ack after 3 cycles): imem_addr stable for all 3 cycles, one push, increment=4 for exactly one cycle.
- Queue holding 2 entries, fetch in WAIT, assert flush for 1 cycle, ack 2 cycles later → dec_valid=0 next cycle, acked data discarded, increment=0, next request uses the current pc.
- Flush coinciding with ack and dec_ready=1 → no push, no pop, count=0, increment=0.
- in=0 asserted mid-WAIT with 3 entries → next cycle imem_req=0, dec_valid=0, increment=0; after release, the first request uses the current pc.
